// File: rtl/shift_pkg.sv
// Shared types for the shift datapath: shift mode encoding and sequencer states.
package shift_pkg;

  typedef enum logic [2:0] {
    SHL = 3'd0,
    SHR = 3'd1,
    ROL = 3'd2,
    ROR = 3'd3,
    ASR = 3'd4
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift of a WIDTH-bit word in one of the shift modes.
// 'active' is low for the reserved mode codes, where the word and out_bit must hold.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  shift_mode_e      mode,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             out_bit,
  output logic             active
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    q       = d;
    out_bit = 1'b0;
    active  = 1'b1;
    case (mode)
      SHL: begin
        q       = {d[WIDTH-2:0], sin};
        out_bit = d[WIDTH-1];
      end
      SHR: begin
        q       = {sin, d[WIDTH-1:1]};
        out_bit = d[0];
      end
      ROL: begin
        q       = {d[WIDTH-2:0], d[WIDTH-1]};
        out_bit = d[WIDTH-1];
      end
      ROR: begin
        q       = {d[0], d[WIDTH-1:1]};
        out_bit = d[0];
      end
      ASR: begin
        q       = {d[WIDTH-1], d[WIDTH-1:1]};
        out_bit = d[0];
      end
      default: active = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_engine.sv
// Multi-mode shift register with a start/busy/done sequencer performing N single-bit shifts.
// Parallel load and start are accepted only in IDLE; ld wins over start.
module shift_engine
  import shift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              AW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] load,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amt,
  input  logic             sin,
  output logic [WIDTH-1:0] shr,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e           state;
  shift_mode_e      mode_q;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    amt_sat;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;
  logic             step_active;

  assign amt_sat = (amt > AW'(WIDTH)) ? AW'(WIDTH) : amt;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .d       (shr),
    .mode    (mode_q),
    .sin     (sin),
    .q       (step_q),
    .out_bit (step_bit),
    .active  (step_active)
  );

  // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= SHL;
      cnt    <= '0;
      shr    <= RST_VAL;
      sout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (ld) begin
            shr <= load;
          end else if (start) begin
            mode_q <= shift_mode_e'(mode);
            cnt    <= amt_sat;
            busy   <= 1'b1;
            if (amt_sat == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          shr <= step_q;
          if (step_active) sout <= step_bit;
          cnt <= cnt - AW'(1);
          if (cnt == AW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
